// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and types for the FIFO-fed multiply-accumulate
// consumer (fifo_mac_consumer and its mac_datapath sub-module).
//   DATA_W_DEF / ACC_W_DEF / LEN_DEF : default operand width, accumulator
//                                      width and pairs consumed per run
//   PROD_W                           : full product width for the defaults
//   mac_state_e                      : control FSM states
//   mac_ctl_t                        : per-cycle control bundle, FSM -> datapath
package mac_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int LEN_DEF    = 8;
  localparam int PROD_W     = 2 * DATA_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_e;

  typedef struct packed {
    logic flush;    // abort: drop in-flight work, zero the accumulator
    logic acc_clr;  // new run starting: zero the accumulator
    logic issue;    // an operand pair is being popped this cycle
  } mac_ctl_t;

endpackage

// File: rtl/mac_datapath.sv
// mac_datapath: product register, accumulator and valid pipeline.
//   clk, rst_n       : clock, async active-low reset
//   ctl              : flush / acc_clr / issue from the control FSM
//   a_data, b_data   : FIFO read data, valid the cycle after issue
//   acc_out          : registered accumulator
//   pipe_pending     : work still ahead of the accumulator stage
// Build option: MAC_SAT_EN -> accumulator saturates at all-ones instead of
// wrapping modulo 2^ACC_W.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mac_ctl_t          ctl,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [ACC_W-1:0]  acc_out,
  output logic              pipe_pending
);

  localparam int PW     = 2 * DATA_W;
  // vld_pipe[0]: FIFO data valid (k+1); vld_pipe[STAGES]: product valid (k+2)
  localparam int STAGES = 1;

  logic [STAGES:0]  vld_pipe;
  logic [PW-1:0]    prod_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

`ifdef MAC_SAT_EN
  // One spare bit catches the carry; products are non-negative, so once
  // pinned at all-ones the sum keeps overflowing and stays pinned.
  logic [ACC_W:0] sum;
  always_comb begin
    sum   = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
    acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end
`else
  always_comb acc_d = acc_q + ACC_W'(prod_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
    end else if (ctl.flush) begin
      vld_pipe <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], ctl.issue};
      if (vld_pipe[0])
        prod_q <= PW'(a_data) * PW'(b_data);
      if (ctl.acc_clr)
        acc_q <= '0;
      else if (vld_pipe[STAGES])
        acc_q <= acc_d;
    end
  end

  // The last stage retires at the end of the current cycle, so only the
  // earlier stages count as outstanding work.
  assign pipe_pending = |vld_pipe[STAGES-1:0];
  assign acc_out      = acc_q;

endmodule

// File: rtl/fifo_mac_consumer.sv
// fifo_mac_consumer: pops LEN operand pairs from two registered-read FIFOs
// in lockstep, multiplies each pair (unsigned) and accumulates the result.
//   clk, rst_n         : clock, async active-low reset
//   start              : begin a run (honoured only in IDLE)
//   clr                : synchronous abort, back to IDLE with acc_out = 0
//   a_empty, b_empty   : FIFO empty flags
//   a_data, b_data     : FIFO read data (one cycle after rden)
//   a_rden, b_rden     : pop strobes, always identical
//   acc_out            : registered accumulator / result
//   busy               : high in RUN and DRAIN
//   done               : one-cycle pulse together with the final result
// Build option: MAC_SAT_EN -> saturating accumulator (see mac_datapath).
module fifo_mac_consumer
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN    = LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  input  logic              a_empty,
  input  logic              b_empty,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              a_rden,
  output logic              b_rden,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] issued_q;
  logic             rden;
  logic             pipe_pending;
  mac_ctl_t         ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rden    = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        rden = !a_empty && !b_empty && (issued_q < LEN_C);
        if (rden && issued_q == LAST_C) state_d = DRAIN;
      end
      DRAIN: if (!pipe_pending) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      rden    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      issued_q <= '0;
    else if (clr || (state_q == IDLE && start))
      issued_q <= '0;
    else if (rden)
      issued_q <= issued_q + CNT_W'(1);
  end

  always_comb begin
    ctl.flush   = clr;
    ctl.acc_clr = (state_q == IDLE) && start;
    ctl.issue   = rden;
  end

  mac_datapath #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctl          (ctl),
    .a_data       (a_data),
    .b_data       (b_data),
    .acc_out      (acc_out),
    .pipe_pending (pipe_pending)
  );

  assign a_rden = rden;
  assign b_rden = rden;
  assign busy   = (state_q == RUN) || (state_q == DRAIN);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_fifo_mac_consumer.sv
// Bench for fifo_mac_consumer: two DUTs (ACC_W=24 and ACC_W=16) share one
// pair of queue-modelled FIFOs; a run-level model checks every cycle and
// directed runs pin the model with literal results.
module tb_fifo_mac_consumer;

  localparam int DW  = 8;
  localparam int AW  = 24;
  localparam int AW2 = 16;
  localparam int LEN = 8;
`ifdef MAC_SAT_EN
  localparam longint MAX16 = 64'h0000_FFFF;
`else
  localparam longint MAX16 = 64'h0000_F008;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, clr, a_empty, b_empty;
  logic [DW-1:0] a_data, b_data;
  logic          a_rden, b_rden, busy, done;
  logic          a_rden16, b_rden16, busy16, done16;
  logic [AW-1:0] acc_out;
  logic [AW2-1:0] acc16;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_rden_cyc = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic          pop_pend = 1'b0;

  // run-level model: phase 0 idle, 1 run, 2 drain, 3 done
  typedef struct { int at; longint val; } land_t;
  land_t  land[$];
  int     ph = 0, issued = 0, done_at = 0;
  longint sum = 0;

  fifo_mac_consumer #(.DATA_W(DW), .ACC_W(AW), .LEN(LEN)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .a_empty(a_empty), .b_empty(b_empty), .a_data(a_data), .b_data(b_data),
    .a_rden(a_rden), .b_rden(b_rden), .acc_out(acc_out), .busy(busy), .done(done));

  fifo_mac_consumer #(.DATA_W(DW), .ACC_W(AW2), .LEN(LEN)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .a_empty(a_empty), .b_empty(b_empty), .a_data(a_data), .b_data(b_data),
    .a_rden(a_rden16), .b_rden(b_rden16), .acc_out(acc16), .busy(busy16), .done(done16));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic longint fold(input longint s, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
`ifdef MAC_SAT_EN
    return (s > m) ? m : s;
`else
    return s & m;
`endif
  endfunction

  // Registered-read FIFO pair: a pop seen mid-cycle presents data next cycle.
  always @(posedge clk) begin
    #2;
    if (pop_pend) begin
      chk("pop_nonempty", longint'(qa.size() > 0 && qb.size() > 0), 1);
      if (qa.size() > 0) a_data = qa.pop_front();
      if (qb.size() > 0) b_data = qb.pop_front();
    end
    a_empty = (qa.size() == 0);
    b_empty = (qb.size() == 0);
  end

  // Per-cycle compare against the model, then advance the model one cycle.
  always @(negedge clk) begin
    logic er;
    cyc++;
    pop_pend = a_rden;
    if (a_rden) last_rden_cyc = cyc;
    if (!rst_n) begin
      ph = 0; sum = 0; issued = 0; land.delete();
      chk("rst_rden", longint'(a_rden | b_rden | a_rden16 | b_rden16), 0);
      chk("rst_busy", longint'(busy | busy16), 0);
      chk("rst_done", longint'(done | done16), 0);
      chk("rst_acc",  longint'(acc_out) + longint'(acc16), 0);
    end else begin
      er = (ph == 1) && !a_empty && !b_empty && (issued < LEN) && !clr;
      chk("rden_a",  a_rden, er);
      chk("rden_b",  b_rden, er);
      chk("rden16",  {a_rden16, b_rden16}, {er, er});
      chk("busy",    busy,   (ph == 1 || ph == 2));
      chk("busy16",  busy16, (ph == 1 || ph == 2));
      chk("done",    done,   (ph == 3));
      chk("done16",  done16, (ph == 3));
      chk("acc",     acc_out, fold(sum, AW));
      chk("acc16",   acc16,   fold(sum, AW2));
      if (clr) begin
        ph = 0; sum = 0; issued = 0; land.delete();
      end else begin
        while (land.size() > 0 && land[0].at == cyc) sum += land.pop_front().val;
        case (ph)
          0: if (start) begin ph = 1; sum = 0; issued = 0; end
          1: if (er) begin
               land.push_back('{cyc + 2, longint'(qa[0]) * longint'(qb[0])});
               issued++;
               if (issued == LEN) begin ph = 2; done_at = cyc + 3; end
             end
          2: if (cyc + 1 == done_at) ph = 3;
          default: ph = 0;
        endcase
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input int n);
    repeat (n) begin qa.push_back(a); qb.push_back(b); end
  endtask

  task automatic wait_done(input string nm, input longint e24, input longint e16);
    int   n;
    logic got;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk); #1; n++;
      if (done) got = 1'b1;
    end
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_acc"},       acc_out, e24);
    chk({nm, "_acc16"},     acc16, e16);
    chk({nm, "_done_lat"},  cyc - last_rden_cyc, 3);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0;
    a_empty = 1'b1; b_empty = 1'b1; a_data = '0; b_data = '0;
    tick(3);
    chk("reset_acc",  acc_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rden", a_rden, 0);
    rst_n = 1'b1; tick(2);

    // basic: A = 1..8, B = 2 -> 72
    for (int i = 1; i <= 8; i++) begin qa.push_back(DW'(i)); qb.push_back(8'd2); end
    tick(); pulse_start();
    wait_done("basic", 72, 72);
    chk("basic_left", qa.size() + qb.size(), 0);
    tick(2);

    // max operands: 8 * 255 * 255 = 520200
    push(8'hFF, 8'hFF, 8);
    tick(); pulse_start();
    wait_done("max", 520200, MAX16);
    tick(2);

    // stall: B holds 4 entries, 4 more arrive later
    for (int i = 1; i <= 8; i++) qa.push_back(DW'(i));
    repeat (4) qb.push_back(8'd2);
    tick(); pulse_start();
    tick(5);
    chk("stall_rden", a_rden, 0);
    chk("stall_busy", busy, 1);
    repeat (4) qb.push_back(8'd2);
    wait_done("stall", 72, 72);
    chk("stall_left", qa.size() + qb.size(), 0);
    tick(2);

    // empty at start, plus a start pulse during RUN
    pulse_start();
    tick(4);
    chk("empty_busy", busy, 1);
    chk("empty_rden", a_rden, 0);
    chk("empty_done", done, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(3);
    chk("empty_busy2", busy, 1);
    push(8'd3, 8'd5, 8);
    wait_done("empty", 120, 120);
    tick(2);

    // abort after 3 pops
    push(8'd4, 8'd4, 8);
    tick(); pulse_start();
    tick(3);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_acc",  acc_out, 0);
    chk("abort_done", done, 0);
    chk("abort_left", qa.size(), 5);
    tick(4);
    qa.delete(); qb.delete();
    tick(2);

    // async reset mid-run
    push(8'd2, 8'd3, 8);
    tick(); pulse_start();
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc",  acc_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rden", a_rden, 0);
    chk("arst_done", done, 0);
    tick(2);
    qa.delete(); qb.delete();
    tick();
    rst_n = 1'b1; tick(2);

    // recovery run after reset
    for (int i = 1; i <= 8; i++) begin qa.push_back(DW'(i)); qb.push_back(8'd2); end
    tick(); pulse_start();
    wait_done("recover", 72, 72);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_mac_consumer.md
Name: fifo_mac_consumer

Overview:
- Downstream consumer of two 8-bit FIFO instances (operand A, operand B).
- On `start`, pops LEN operand pairs in lockstep, multiplies each pair (unsigned) and accumulates into a result register.
- Pulses `done` when the final accumulation lands.
- Sits between the operand FIFOs and the result/display logic of the minilab datapath.

Parameters:
- DATA_W, 8, operand width; matches FIFO data width.
- ACC_W, 24, accumulator and result width.
- LEN, 8, operand pairs consumed per run; matches FIFO depth; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- clr  in  1  synchronous abort/clear; highest priority after reset.
- a_empty  in  1  empty flag of FIFO A.
- b_empty  in  1  empty flag of FIFO B.
- a_data  in  DATA_W  FIFO A read data; valid the cycle after a_rden (registered FIFO read).
- b_data  in  DATA_W  FIFO B read data; same timing as a_data.
- a_rden  out  1  pop FIFO A.
- b_rden  out  1  pop FIFO B; always identical to a_rden.
- acc_out  out  ACC_W  accumulator value, registered.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc_out=0; a_rden=b_rden=0; busy=0; done=0; issue counter=0; all pipeline valid bits=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> acc_out cleared to 0, issue count=0, go to RUN next cycle. acc_out otherwise holds the previous result.
  - RUN, read rule: a_rden=b_rden=1 (combinational) iff !a_empty && !b_empty && issued<LEN. Each asserted cycle increments issued.
  - RUN, stall: if either FIFO is empty, no pop that cycle; wait indefinitely with no timeout.
  - RUN -> DRAIN: on the cycle issued reaches LEN.
  - DRAIN: no reads. Wait until all pipeline valid bits clear, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Pipeline (read issued in cycle k):
  - k+1: a_data/b_data valid; product register loads a_data*b_data (2*DATA_W bits, unsigned).
  - k+2: product valid; accumulator adds the zero-extended product at end of cycle.
  - Final acc_out is visible from cycle k+3 of the last read. done is high in that same cycle k+3.
- Back-to-back reads every cycle are supported: one pair per cycle throughput.
- Arithmetic: accumulation is modulo 2^ACC_W (wrap) unless MAC_SAT_EN is defined.
- start while busy or in DONE: ignored.
- clr=1 in any state:
  - next state IDLE; acc_out=0; pipeline valid bits and issue count cleared; rden deasserted that cycle.
  - In-flight FIFO data is discarded.
- Async reset mid-run: immediate return to the reset values above. FIFO contents are not this block's concern.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_W-1. Once saturated it stays there until the next start, clr, or reset.
- Undefined: wrap-around modulo 2^ACC_W.

Decomposition:
- Shared package mac_pkg:
  - default DATA_W/ACC_W/LEN constants;
  - state enum type (IDLE, RUN, DRAIN, DONE);
  - product width constant PROD_W = 2*DATA_W.
- One sub-module, mac_datapath: product register, accumulator, valid pipeline, saturation logic.
- The top level holds the FSM, issue counter and rden generation.

Test Plan:
- Basic run: prefill FIFO A with 1..8, FIFO B with 8×2, pulse start -> 8 consecutive rden cycles; done 3 cycles after the last rden; acc_out=72 (0x000048).
- Max operands: A=B=0xFF ×8 -> acc_out=520200 (0x07F008); no overflow at ACC_W=24.
- Stall: B holds only 4 entries, then 4 more written 5 cycles later -> rden drops while b_empty=1; exactly 8 pops total; result matches the unstalled run.
- Empty at start: both FIFOs empty, start -> busy=1, no rden, no done until data arrives; start pulses during RUN are ignored.
- Overflow with ACC_W=16 override, A=B=0xFF ×8 -> without MAC_SAT_EN acc_out=0xF008; with MAC_SAT_EN acc_out=0xFFFF.
- Abort: clr after 3 pops -> next cycle IDLE, acc_out=0, busy=0, no done. Async rst_n low mid-RUN -> all outputs at reset values immediately.
